// File: rtl/gmii_rx_framer_if.sv
// rtl/gmii_rx_framer_if.sv - SDR GMII receive byte bus
interface gmii_if;
  logic [7:0] data;
  logic       valid;
  logic       error;

  modport master (output data, output valid, output error);
  modport slave  (input  data, input  valid, input  error);
endinterface

// File: rtl/gmii_rx_framer.sv
// rtl/gmii_rx_framer.sv - GMII RX preamble/SFD strip, frame delimiting and status
module gmii_rx_framer #(
  parameter int MIN_FRAME_LEN = 64,
  parameter int MAX_FRAME_LEN = 1518,
  parameter int LEN_W         = 16
) (
  input  logic             clk,
  input  logic             rst,
  gmii_if.slave            gmii_if_rx_i,
  output logic [7:0]       m_data_o,
  output logic             m_valid_o,
  output logic             m_last_o,
  output logic             m_user_o,
  output logic             frame_done_o,
  output logic [LEN_W-1:0] frame_len_o,
  output logic [2:0]       err_flags_o
);

  typedef enum logic [1:0] {IDLE, PREAMBLE, PAYLOAD, DROP} state_t;

  localparam logic [LEN_W-1:0] MIN_L = LEN_W'(MIN_FRAME_LEN);
  localparam logic [LEN_W-1:0] MAX_L = LEN_W'(MAX_FRAME_LEN);

  state_t           state_q, state_d;
  logic [7:0]       hold_q, hold_d;
  logic             hold_full_q, hold_full_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             gerr_q, gerr_d;
  logic [7:0]       m_data_q, m_data_d;
  logic             m_valid_q, m_valid_d;
  logic             m_last_q, m_last_d;
  logic             m_user_q, m_user_d;
  logic             done_q, done_d;
  logic [LEN_W-1:0] flen_q, flen_d;
  logic [2:0]       flags_q, flags_d;
  logic             runt_c;

  assign runt_c = (len_q < MIN_L);

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    len_d       = len_q;
    gerr_d      = gerr_q;
    m_data_d    = m_data_q;
    m_valid_d   = 1'b0;
    m_last_d    = 1'b0;
    m_user_d    = 1'b0;
    done_d      = 1'b0;
    flen_d      = flen_q;
    flags_d     = flags_q;

    case (state_q)
      IDLE: begin
        hold_full_d = 1'b0;
        if (gmii_if_rx_i.valid) begin
          state_d = (gmii_if_rx_i.data == 8'h55 && !gmii_if_rx_i.error) ? PREAMBLE : DROP;
        end
      end
      PREAMBLE: begin
        if (!gmii_if_rx_i.valid) begin
          state_d = IDLE;
        end else if (!gmii_if_rx_i.error && gmii_if_rx_i.data == 8'h55) begin
          state_d = PREAMBLE;
        end else if (!gmii_if_rx_i.error && gmii_if_rx_i.data == 8'hD5) begin
          state_d     = PAYLOAD;
          len_d       = '0;
          gerr_d      = 1'b0;
          hold_full_d = 1'b0;
        end else begin
          state_d = DROP;
        end
      end
      PAYLOAD: begin
        if (gmii_if_rx_i.valid) begin
          if (hold_full_q && len_q == MAX_L) begin
            // Byte MAX+1: close the frame on the held byte and discard this one.
            m_valid_d   = 1'b1;
            m_data_d    = hold_q;
            m_last_d    = 1'b1;
            m_user_d    = 1'b1;
            done_d      = 1'b1;
            flen_d      = len_q;
            flags_d     = {1'b1, runt_c, gerr_q};
            hold_full_d = 1'b0;
            state_d     = DROP;
          end else begin
            if (hold_full_q) begin
              m_valid_d = 1'b1;
              m_data_d  = hold_q;
            end
            hold_d      = gmii_if_rx_i.data;
            hold_full_d = 1'b1;
            if (len_q != '1) len_d = len_q + 1'b1;
            if (gmii_if_rx_i.error) gerr_d = 1'b1;
          end
        end else begin
          if (hold_full_q) begin
            m_valid_d = 1'b1;
            m_data_d  = hold_q;
            m_last_d  = 1'b1;
            m_user_d  = runt_c | gerr_q;
            done_d    = 1'b1;
            flen_d    = len_q;
            flags_d   = {1'b0, runt_c, gerr_q};
          end
          hold_full_d = 1'b0;
          state_d     = IDLE;
        end
      end
      DROP: begin
        hold_full_d = 1'b0;
        if (!gmii_if_rx_i.valid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      len_q       <= '0;
      gerr_q      <= 1'b0;
      m_data_q    <= '0;
      m_valid_q   <= 1'b0;
      m_last_q    <= 1'b0;
      m_user_q    <= 1'b0;
      done_q      <= 1'b0;
      flen_q      <= '0;
      flags_q     <= '0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      len_q       <= len_d;
      gerr_q      <= gerr_d;
      m_data_q    <= m_data_d;
      m_valid_q   <= m_valid_d;
      m_last_q    <= m_last_d;
      m_user_q    <= m_user_d;
      done_q      <= done_d;
      flen_q      <= flen_d;
      flags_q     <= flags_d;
    end
  end

  assign m_data_o     = m_data_q;
  assign m_valid_o    = m_valid_q;
  assign m_last_o     = m_last_q;
  assign m_user_o     = m_user_q;
  assign frame_done_o = done_q;
  assign frame_len_o  = flen_q;
  assign err_flags_o  = flags_q;

endmodule

// File: tb/tb_gmii_rx_framer.sv
// tb/tb_gmii_rx_framer.sv - scoreboard bench for gmii_rx_framer
module tb_gmii_rx_framer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  m_data;
  logic        m_valid, m_last, m_user, frame_done;
  logic [15:0] frame_len;
  logic [2:0]  err_flags;

  int checks = 0;
  int errors = 0;

  typedef struct packed {logic [7:0] d; logic l; logic u;} beat_t;
  typedef struct packed {logic [15:0] len; logic [2:0] fl;} stat_t;
  beat_t beat_q[$];
  stat_t stat_q[$];

  gmii_if rx ();

  gmii_rx_framer #(.MIN_FRAME_LEN(64), .MAX_FRAME_LEN(1518), .LEN_W(16)) dut (
    .clk          (clk),
    .rst          (rst_n),
    .gmii_if_rx_i (rx),
    .m_data_o     (m_data),
    .m_valid_o    (m_valid),
    .m_last_o     (m_last),
    .m_user_o     (m_user),
    .frame_done_o (frame_done),
    .frame_len_o  (frame_len),
    .err_flags_o  (err_flags)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every beat and every frame_done pops its expectation.
  always @(negedge clk) begin
    if (rst_n) begin
      if (m_valid) begin
        if (beat_q.size() == 0) begin
          chk("unexpected_beat", {24'd0, m_data}, 32'hFFFF_FFFF);
        end else begin
          beat_t b;
          b = beat_q.pop_front();
          chk("beat_data", {24'd0, m_data}, {24'd0, b.d});
          chk("beat_last", {31'd0, m_last}, {31'd0, b.l});
          if (b.l) chk("beat_user", {31'd0, m_user}, {31'd0, b.u});
        end
      end else if (m_last) begin
        chk("last_without_valid", 32'd1, 32'd0);
      end
      if (frame_done) begin
        chk("done_with_last", {31'd0, m_last & m_valid}, 32'd1);
        if (stat_q.size() == 0) begin
          chk("unexpected_frame_done", {16'd0, frame_len}, 32'hFFFF_FFFF);
        end else begin
          stat_t s;
          s = stat_q.pop_front();
          chk("frame_len", {16'd0, frame_len}, {16'd0, s.len});
          chk("err_flags", {29'd0, err_flags}, {29'd0, s.fl});
        end
      end
    end
  end

  task automatic send(input logic [7:0] d, input logic e);
    rx.data  = d;
    rx.valid = 1'b1;
    rx.error = e;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input logic e);
    rx.data  = 8'h00;
    rx.valid = 1'b0;
    rx.error = e;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
    rx.error = 1'b0;
  endtask

  // Payload bytes are i[7:0]; expectations are given explicitly per frame.
  task automatic frame(input int npay, input int err_idx, input int exp_beats,
                       input logic exp_user, input logic [15:0] exp_len,
                       input logic [2:0] exp_fl, input bit chk_lat);
    for (int i = 0; i < exp_beats; i++) begin
      beat_t b;
      b.d = 8'(i);
      b.l = (i == exp_beats - 1);
      b.u = exp_user;
      beat_q.push_back(b);
    end
    if (exp_beats > 0) stat_q.push_back({exp_len, exp_fl});
    repeat (7) send(8'h55, 1'b0);
    send(8'hD5, 1'b0);
    for (int i = 0; i < npay; i++) begin
      send(8'(i), (i == err_idx));
      if (chk_lat && i == 0) chk("latency_not_yet", {31'd0, m_valid}, 32'd0);
      if (chk_lat && i == 1) chk("latency_first_beat", {23'd0, m_valid, m_data}, 32'h100);
    end
    idle(1, 1'b1);
  endtask

  initial begin
    rx.data  = 8'h00;
    rx.valid = 1'b0;
    rx.error = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_valid", {31'd0, m_valid}, 32'd0);
    chk("reset_outs", {m_data, m_last, m_user, frame_done, err_flags, frame_len},
        32'd0);
    rst_n = 1'b1;
    idle(2, 1'b0);

    frame(64, -1, 64, 1'b0, 16'd64, 3'b000, 1'b1);
    frame(10, -1, 10, 1'b1, 16'd10, 3'b010, 1'b0);
    frame(100, 49, 100, 1'b1, 16'd100, 3'b001, 1'b0);
    frame(1600, -1, 1518, 1'b1, 16'd1518, 3'b100, 1'b0);
    chk("oversize_drop_quiet", {31'd0, m_valid}, 32'd0);

    send(8'h55, 1'b0); send(8'h55, 1'b0); send(8'hAA, 1'b0);
    send(8'hD5, 1'b0); send(8'h01, 1'b0); send(8'h02, 1'b0);
    idle(1, 1'b0);
    frame(64, -1, 64, 1'b0, 16'd64, 3'b000, 1'b0);

    repeat (7) send(8'h55, 1'b0);
    send(8'hD5, 1'b0);
    idle(1, 1'b0);
    frame(64, -1, 64, 1'b0, 16'd64, 3'b000, 1'b0);

    // Reset lands mid-frame: beats 0..27 are seen before rst falls.
    for (int i = 0; i < 28; i++) beat_q.push_back({8'(i), 1'b0, 1'b0});
    repeat (7) send(8'h55, 1'b0);
    send(8'hD5, 1'b0);
    for (int i = 0; i < 30; i++) send(8'(i), 1'b0);
    rst_n = 1'b0;
    #1;
    chk("rst_async_valid", {31'd0, m_valid}, 32'd0);
    chk("rst_async_outs", {m_data, m_last, m_user, frame_done, err_flags, frame_len},
        32'd0);
    for (int i = 30; i < 40; i++) send(8'(i), 1'b0);
    rst_n = 1'b1;
    for (int i = 40; i < 64; i++) send(8'(i), 1'b0);
    idle(1, 1'b0);
    frame(64, -1, 64, 1'b0, 16'd64, 3'b000, 1'b0);

    idle(10, 1'b0);
    chk("beats_left", beat_q.size(), 32'd0);
    chk("frames_left", stat_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
